uart_tx_cfg: RTL and testbench

Parametrised UART transmitter for the serial I/O subsystem. It is the configurable successor to the fixed 8-bit even-parity transmitter. Data width, parity mode, stop-bit count and baud rate are set at elaboration. Bytes are accepted over a valid/ready handshake and serialised LSB-first onto a single line that idles high.

---
 rtl/uart_tx_cfg.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// uart_tx_cfg
//
// Configurable UART transmitter. A word is accepted over a valid/ready
// handshake and sent LSB-first on a line that idles high. Each frame is:
// start (0), DATA_BITS data bits, an optional parity bit, then STOP_BITS
// stop bits (1). Every bit lasts DIV = CLK_RATE/BR clock cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   tx_data    word to send, captured when tx_valid && tx_ready
//   tx_valid   tx_data holds a word to send
//   tx_ready   high while idle; a word may be accepted this cycle
//   tx_active  high from the start bit through the last stop bit
//   tx_serial  serial output line, idles high
//   tx_done    one-cycle pulse in the first idle cycle after a frame
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int CLK_RATE    = 50000000,
    parameter int BR          = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_active,
    output logic                 tx_serial,
    output logic                 tx_done
);

    localparam int DIV   = CLK_RATE / BR;
    // Keep the width at least one bit so an illegal DIV still reaches the
    // parameter check below instead of failing on a zero-width vector.
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_tx_cfg: illegal parameter set (DIV=%0d DATA_BITS=%0d PARITY_MODE=%0d STOP_BITS=%0d)",
                   DIV, DATA_BITS, PARITY_MODE, STOP_BITS);
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       baud_cnt_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   tx_serial_q;
    logic                   tx_ready_q;
    logic                   tx_active_q;
    logic                   tx_done_q;

    logic                   baud_wrap;
    logic [CNT_W-1:0]       baud_cnt_d;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   parity_d;

    always_comb begin
        baud_wrap  = (baud_cnt_q == BAUD_LAST);
        baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CNT_W'(1);
        shift_d    = shift_q >> 1;
        // Odd parity is the inverted even parity of the word being accepted.
        parity_d   = (^tx_data) ^ (PARITY_MODE == 2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    baud_cnt_q  <= '0;
                    bit_idx_q   <= '0;
                    tx_serial_q <= 1'b1;
                    tx_ready_q  <= 1'b1;
                    tx_active_q <= 1'b0;
                    if (tx_valid && tx_ready_q) begin
                        shift_q     <= tx_data;
                        parity_q    <= parity_d;
                        state_q     <= S_START;
                        tx_serial_q <= 1'b0;
                        tx_ready_q  <= 1'b0;
                        tx_active_q <= 1'b1;
                    end
                end
                S_START: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_wrap) begin
                        state_q     <= S_DATA;
                        tx_serial_q <= shift_q[0];
                    end
                end
                S_DATA: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_wrap) begin
                        shift_q <= shift_d;
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            if (PARITY_MODE != 0) begin
                                state_q     <= S_PARITY;
                                tx_serial_q <= parity_q;
                            end else begin
                                state_q     <= S_STOP;
                                tx_serial_q <= 1'b1;
                            end
                        end else begin
                            bit_idx_q   <= bit_idx_q + IDX_W'(1);
                            // The line is registered, so show the bit that
                            // becomes shift[0] after this shift.
                            tx_serial_q <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_wrap) begin
                        state_q     <= S_STOP;
                        tx_serial_q <= 1'b1;
                    end
                end
                S_STOP: begin
                    baud_cnt_q  <= baud_cnt_d;
                    tx_serial_q <= 1'b1;
                    if (baud_wrap) begin
                        if (bit_idx_q == STOP_LAST) begin
                            state_q     <= S_IDLE;
                            bit_idx_q   <= '0;
                            tx_ready_q  <= 1'b1;
                            tx_active_q <= 1'b0;
                            tx_done_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    baud_cnt_q  <= '0;
                    bit_idx_q   <= '0;
                    tx_serial_q <= 1'b1;
                    tx_ready_q  <= 1'b1;
                    tx_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready  = tx_ready_q;
    assign tx_active = tx_active_q;
    assign tx_serial = tx_serial_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Runs four configurations of uart_tx_cfg side by side (8E1 DIV=10,
// 8O1 DIV=10, 7N2 DIV=10, 8E1 DIV=2). Each one has a frame-level model that
// predicts every output on every cycle from the position inside the frame,
// plus literal expectations for selected words.
// ----------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    localparam int NI = 4;
    localparam int P_CLK [NI] = '{100, 100, 100, 20};
    localparam int P_DB  [NI] = '{8, 8, 7, 8};
    localparam int P_PM  [NI] = '{1, 2, 0, 1};
    localparam int P_SB  [NI] = '{1, 1, 2, 1};
    // Directed words, the line level sampled at the start of each bit
    // (bit i of the vector = frame bit i), and the tx_done cycle.
    localparam int W0 [NI] = '{'hA5, 'hA5, 'h7F, 'hFF};
    localparam int L0 [NI] = '{'b10101001010, 'b11101001010, 'b1111111110, 'b10111111110};
    localparam int W1 [NI] = '{'h3C, 'h01, 'h00, 'h00};
    localparam int L1 [NI] = '{'b10001111000, 'b10000000010, 'b1100000000, 'b10000000000};
    localparam int DN [NI] = '{111, 111, 101, 23};

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_inst
            localparam int DIV = P_CLK[gi] / 10;
            localparam int DB  = P_DB[gi];
            localparam int PM  = P_PM[gi];
            localparam int SB  = P_SB[gi];
            localparam int NB  = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
            localparam int FL  = NB * DIV;

            logic          rst_n    = 1'b1;
            logic [DB-1:0] tx_data  = '0;
            logic          tx_valid = 1'b0;
            logic          tx_ready;
            logic          tx_active;
            logic          tx_serial;
            logic          tx_done;
            logic          fin      = 1'b0;

            uart_tx_cfg #(
                .CLK_RATE   (P_CLK[gi]),
                .BR         (10),
                .DATA_BITS  (DB),
                .PARITY_MODE(PM),
                .STOP_BITS  (SB)
            ) u_dut (
                .clk      (clk),
                .reset_n  (rst_n),
                .tx_data  (tx_data),
                .tx_valid (tx_valid),
                .tx_ready (tx_ready),
                .tx_active(tx_active),
                .tx_serial(tx_serial),
                .tx_done  (tx_done)
            );

            // Level of frame bit idx for word w: start, data LSB first,
            // optional parity, then stop bits.
            function automatic logic frame_bit(input logic [DB-1:0] w, input int idx);
                int ones;
                ones = 0;
                for (int i = 0; i < DB; i++) ones += int'(w[i]);
                if (idx == 0) return 1'b0;
                if (idx <= DB) return w[idx-1];
                if (PM != 0 && idx == DB + 1) return ((ones % 2) == 1) ^ (PM == 2);
                return 1'b1;
            endfunction

            // k = cycles since acceptance: 1..FL inside the frame, FL+1 is
            // the done cycle, 0 is plain idle.
            int            k      = 0;
            logic [DB-1:0] word_m = '0;

            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    k <= 0;
                end else if (k == 0 || k == FL + 1) begin
                    if (tx_valid) begin
                        k      <= 1;
                        word_m <= tx_data;
                        $display("inst %0d: frame accepted, data=0x%0h, t=%0t", gi, tx_data, $time);
                    end else begin
                        k <= 0;
                    end
                end else begin
                    k <= k + 1;
                end
            end

            always @(negedge clk) begin
                check($sformatf("i%0d tx_serial k=%0d", gi, k), int'(tx_serial),
                      (k >= 1 && k <= FL) ? int'(frame_bit(word_m, (k - 1) / DIV)) : 1);
                check($sformatf("i%0d tx_active k=%0d", gi, k), int'(tx_active),
                      (k >= 1 && k <= FL) ? 1 : 0);
                check($sformatf("i%0d tx_ready k=%0d", gi, k), int'(tx_ready),
                      (k >= 1 && k <= FL) ? 0 : 1);
                check($sformatf("i%0d tx_done k=%0d", gi, k), int'(tx_done),
                      (k == FL + 1) ? 1 : 0);
            end

            // Send one word, measuring done cycle, active cycles and the
            // line level at the first cycle of each bit. Called and returns
            // at a falling edge.
            task automatic send(input logic [DB-1:0] w, output int done_n,
                                output int act_n, output int bits);
                int guard;
                guard = 0;
                while (!tx_ready && guard < 4 * FL) begin
                    @(negedge clk);
                    guard++;
                end
                check($sformatf("i%0d ready before send", gi), int'(tx_ready), 1);
                tx_data  = w;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                done_n = -1;
                act_n  = 0;
                bits   = 0;
                for (int n = 1; n <= FL + 5; n++) begin
                    if (tx_done) begin
                        done_n = n;
                        break;
                    end
                    if (tx_active) act_n++;
                    if ((n - 1) % DIV == 0 && (n - 1) / DIV < 31)
                        bits |= int'(tx_serial) << ((n - 1) / DIV);
                    @(negedge clk);
                end
                $display("inst %0d: sent 0x%0h, done at cycle %0d, active %0d, bits 0x%0h",
                         gi, w, done_n, act_n, bits);
            endtask

            initial begin : stim
                int            dn, an, bv, run, pulses, tmp;
                logic          seen_done;
                logic [DB-1:0] w;

                #1 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check($sformatf("i%0d reset tx_serial", gi), int'(tx_serial), 1);
                check($sformatf("i%0d reset tx_ready", gi), int'(tx_ready), 1);
                check($sformatf("i%0d reset tx_active", gi), int'(tx_active), 0);
                check($sformatf("i%0d reset tx_done", gi), int'(tx_done), 0);
                #2 rst_n = 1'b1;
                @(negedge clk);

                // Directed word 0 with literal frame checks.
                tmp = W0[gi];
                w   = tmp[DB-1:0];
                send(w, dn, an, bv);
                check($sformatf("i%0d w0 done cycle", gi), dn, DN[gi]);
                check($sformatf("i%0d w0 active cycles", gi), an, DN[gi] - 1);
                check($sformatf("i%0d w0 bit levels", gi), bv, L0[gi]);

                // Back-to-back with tx_valid held; data changes mid-frame.
                tmp = (PM == 2) ? 'h01 : 'h11;
                tx_data  = tmp[DB-1:0];
                tx_valid = 1'b1;
                @(negedge clk);
                tmp = 'h22;
                tx_data   = tmp[DB-1:0];
                run       = 0;
                seen_done = 1'b0;
                for (int n = 0; n < 2 * FL + 10; n++) begin
                    if (tx_done) begin
                        seen_done = 1'b1;
                        check($sformatf("i%0d b2b ready with done", gi), int'(tx_ready), 1);
                    end
                    if (tx_serial) begin
                        run++;
                    end else begin
                        if (seen_done) break;
                        run = 0;
                    end
                    @(negedge clk);
                end
                tx_valid = 1'b0;
                check($sformatf("i%0d b2b done seen", gi), int'(seen_done), 1);
                check($sformatf("i%0d b2b inter-frame high", gi), run, SB * DIV + 1);
                for (int n = 0; n < FL + 5 && !tx_done; n++) @(negedge clk);
                check($sformatf("i%0d b2b frame2 done", gi), int'(tx_done), 1);
                @(negedge clk);

                // Reset in the middle of the first data bit.
                tx_data  = '0;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (DIV + DIV / 2) @(negedge clk);
                check($sformatf("i%0d pre-reset line low", gi), int'(tx_serial), 0);
                #2 rst_n = 1'b0;
                #1;
                check($sformatf("i%0d async reset tx_serial", gi), int'(tx_serial), 1);
                check($sformatf("i%0d async reset tx_active", gi), int'(tx_active), 0);
                check($sformatf("i%0d async reset tx_ready", gi), int'(tx_ready), 1);
                check($sformatf("i%0d async reset tx_done", gi), int'(tx_done), 0);
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
                pulses = 0;
                for (int n = 0; n < FL + 3; n++) begin
                    if (tx_done) pulses++;
                    @(negedge clk);
                end
                check($sformatf("i%0d no done after abort", gi), pulses, 0);

                // Directed word 1 after the aborted frame.
                tmp = W1[gi];
                w   = tmp[DB-1:0];
                send(w, dn, an, bv);
                check($sformatf("i%0d w1 done cycle", gi), dn, DN[gi]);
                check($sformatf("i%0d w1 active cycles", gi), an, DN[gi] - 1);
                check($sformatf("i%0d w1 bit levels", gi), bv, L1[gi]);

                // Random traffic, including tx_valid while busy.
                for (int n = 0; n < 1500; n++) begin
                    tx_valid = ($urandom_range(0, 2) == 0);
                    tx_data  = DB'($urandom());
                    @(negedge clk);
                end
                tx_valid = 1'b0;
                repeat (FL + 5) @(negedge clk);
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin : main
        int guard;
        guard = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin)
               && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        check("all instances finished", int'(g_inst[0].fin && g_inst[1].fin &&
                                             g_inst[2].fin && g_inst[3].fin), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
